// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one Avalon-MM slave between two masters.
//               Master 0 is a read-only stim engine. Master 1 is the host port
//               and can read and write. Grants are round-robin, and the owner
//               keeps the slave for at most MAX_HOLD accepted commands while the
//               other master waits. The command path is a zero-latency mux.
//               Each pipelined read records its requester in a tag FIFO, so
//               every read return goes back to the master that issued it.
// Ports       : clock, reset        - clock; asynchronous active-high reset
//               m0_*                - master 0 (read-only) Avalon-MM port
//               m1_*                - master 1 (read/write) Avalon-MM port
//               s_*                 - shared slave Avalon-MM port
//               grant, busy         - current owner; an owner state is active
//               tag_err             - sticky: read return with nothing pending
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int TAG_DEPTH  = 8,
  parameter int TAG_AW     = 3,
  parameter int HOLD_WIDTH = 4,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  // master 0 (read-only)
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic                  m0_read,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdataready,
  output logic                  m0_waitrequest,
  // master 1 (read/write)
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdataready,
  output logic                  m1_waitrequest,
  // shared slave
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [BE_WIDTH-1:0]   s_byteenable,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_WIDTH-1:0] s_writedata,
  input  logic [DATA_WIDTH-1:0] s_readdata,
  input  logic                  s_readdataready,
  input  logic                  s_waitrequest,
  // status
  output logic                  grant,
  output logic                  busy,
  output logic                  tag_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  localparam logic [HOLD_WIDTH-1:0] C_HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);
  localparam logic [TAG_AW:0]       C_TAG_FULL  = (TAG_AW + 1)'(TAG_DEPTH);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic [HOLD_WIDTH-1:0] r_hold_cnt;
  logic                  r_tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0]     r_wr_ptr;
  logic [TAG_AW-1:0]     r_rd_ptr;
  logic [TAG_AW:0]       r_count;
  logic                  r_tag_err;

  logic w_req0;
  logic w_req1;
  logic w_owner;
  logic w_own_read;
  logic w_own_write;
  logic w_owner_wait;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_req_own;
  logic w_req_other;
  logic w_exit;

  assign w_req0       = m0_read;
  assign w_req1       = m1_read | m1_write;
  assign w_owner      = (r_state == S_OWN1);
  assign w_fifo_full  = (r_count == C_TAG_FULL);
  assign w_fifo_empty = (r_count == '0);

  // --------------------------------------------------------------------------
  // Command mux: the owning master drives the slave directly. On master 1 a
  // simultaneous read and write lets the write through; the read waits.
  // --------------------------------------------------------------------------
  always_comb begin
    w_own_read   = 1'b0;
    w_own_write  = 1'b0;
    s_address    = '0;
    s_byteenable = '0;
    s_writedata  = '0;
    case (r_state)
      S_OWN0: begin
        w_own_read   = m0_read;
        s_address    = m0_address;
        s_byteenable = m0_byteenable;
      end
      S_OWN1: begin
        w_own_write  = m1_write;
        w_own_read   = m1_read & ~m1_write;
        s_address    = m1_address;
        s_byteenable = m1_byteenable;
        s_writedata  = m1_writedata;
      end
      default: ;
    endcase
  end

  // A full tag FIFO blocks only reads; writes keep flowing.
  assign s_read         = w_own_read & ~w_fifo_full;
  assign s_write        = w_own_write;
  assign w_owner_wait   = s_waitrequest | (w_own_read & w_fifo_full);
  assign m0_waitrequest = (r_state == S_OWN0) ? w_owner_wait : 1'b1;
  assign m1_waitrequest = (r_state == S_OWN1) ? w_owner_wait : 1'b1;

  assign w_accept = (s_read | s_write) & ~s_waitrequest;
  assign w_push   = s_read & ~s_waitrequest;
  assign w_pop    = s_readdataready & ~w_fifo_empty;
  assign w_head   = r_tag_mem[r_rd_ptr];

  // Read data fans out to both masters; only the FIFO head sees the strobe.
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdataready = w_pop & ~w_head;
  assign m1_readdataready = w_pop &  w_head;

  assign grant   = w_owner;
  assign busy    = (r_state != S_IDLE);
  assign tag_err = r_tag_err;

  // --------------------------------------------------------------------------
  // Next-state logic. From IDLE a tie goes to the master that did not own the
  // slave last. An owner leaves when it stops requesting, or when its
  // MAX_HOLD-th accepted command completes while the other master waits.
  // Hand-over goes straight to the other owner state, with no IDLE bubble.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_exit       = 1'b0;
    w_req_own    = 1'b0;
    w_req_other  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req0 & w_req1) begin
          w_next_state = r_last_grant ? S_OWN0 : S_OWN1;
        end else if (w_req0) begin
          w_next_state = S_OWN0;
        end else if (w_req1) begin
          w_next_state = S_OWN1;
        end
      end
      S_OWN0, S_OWN1: begin
        w_req_own   = w_owner ? w_req1 : w_req0;
        w_req_other = w_owner ? w_req0 : w_req1;
        if (~w_req_own | (w_accept & (r_hold_cnt == C_HOLD_LAST) & w_req_other)) begin
          w_exit = 1'b1;
          if (w_req_other) begin
            w_next_state = w_owner ? S_OWN0 : S_OWN1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_hold_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_exit) begin
        r_last_grant <= w_owner;
        r_hold_cnt   <= '0;
      end else if (w_accept) begin
        // The compare is exact, so if the limit passes with nobody waiting
        // the counter keeps running and wraps before the limit applies again.
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Requester-ID FIFO. Storage needs no reset: the count marks what is valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_owner;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tag_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A return with nothing outstanding is dropped and flagged.
      if (s_readdataready & w_fifo_empty) begin
        r_tag_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Randomised self-checking bench for mem_arbiter. A cycle-level
//               reference model tracks the owner, hold count and a queue of
//               outstanding read requesters. It predicts every output on
//               every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW       = 20;
  localparam int DW       = 16;
  localparam int BW       = DW / 8;
  localparam int DEPTH    = 8;
  localparam int MAX_HOLD = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] m0_address = '0;
  logic [BW-1:0] m0_byteenable = '0;
  logic          m0_read = 1'b0;
  logic [DW-1:0] m0_readdata;
  logic          m0_readdataready;
  logic          m0_waitrequest;
  logic [AW-1:0] m1_address = '0;
  logic [BW-1:0] m1_byteenable = '0;
  logic          m1_read = 1'b0;
  logic          m1_write = 1'b0;
  logic [DW-1:0] m1_writedata = '0;
  logic [DW-1:0] m1_readdata;
  logic          m1_readdataready;
  logic          m1_waitrequest;
  logic [AW-1:0] s_address;
  logic [BW-1:0] s_byteenable;
  logic          s_read;
  logic          s_write;
  logic [DW-1:0] s_writedata;
  logic [DW-1:0] s_readdata = '0;
  logic          s_readdataready = 1'b0;
  logic          s_waitrequest = 1'b0;
  logic          grant;
  logic          busy;
  logic          tag_err;

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TAG_DEPTH(DEPTH),
    .TAG_AW(3), .HOLD_WIDTH(4), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_readdata(m0_readdata), .m0_readdataready(m0_readdataready),
    .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m1_readdataready(m1_readdataready), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .s_readdataready(s_readdataready), .s_waitrequest(s_waitrequest),
    .grant(grant), .busy(busy), .tag_err(tag_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model state: owner (-1 = none), last owner, hold count,
  // queue of outstanding read requesters, sticky error.
  int m_own  = -1;
  int m_last = 1;
  int m_hold = 0;
  bit m_q[$];
  bit m_err  = 1'b0;

  // Counters for how often interesting situations were reached.
  int n_handover = 0;
  int n_full     = 0;

  function automatic bit chance(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_last = 1;
    m_hold = 0;
    m_q.delete();
    m_err  = 1'b0;
  endtask

  // One clock cycle: drive random inputs, predict and check all outputs,
  // then advance the model to the state after the coming rising edge.
  task automatic run_cycle(input int p0, input int p1r, input int p1w,
                           input int pwait, input int pret, input int pbad);
    bit            rd, wr, full, esr, ew0, ew1, pop, head, acc, req0, req1, reqx, reqy;
    logic [AW-1:0] ea;
    logic [BW-1:0] ebe;
    logic [DW-1:0] ewd;
    @(negedge clock);
    m0_read         = chance(p0);
    m0_address      = AW'($urandom);
    m0_byteenable   = BW'($urandom);
    m1_read         = chance(p1r);
    m1_write        = chance(p1w);
    m1_address      = AW'($urandom);
    m1_byteenable   = BW'($urandom);
    m1_writedata    = DW'($urandom);
    s_waitrequest   = chance(pwait);
    s_readdata      = DW'($urandom);
    s_readdataready = (m_q.size() > 0) ? chance(pret) : chance(pbad);
    #1;
    rd = 1'b0; wr = 1'b0; ea = '0; ebe = '0; ewd = '0;
    if (m_own == 0) begin
      rd = m0_read; ea = m0_address; ebe = m0_byteenable;
    end else if (m_own == 1) begin
      wr = m1_write; rd = m1_read && !m1_write;
      ea = m1_address; ebe = m1_byteenable; ewd = m1_writedata;
    end
    full = (m_q.size() >= DEPTH);
    if (full && rd) n_full++;
    esr  = rd && !full;
    ew0  = (m_own == 0) ? (s_waitrequest || (rd && full)) : 1'b1;
    ew1  = (m_own == 1) ? (s_waitrequest || (rd && full)) : 1'b1;
    pop  = s_readdataready && (m_q.size() > 0);
    head = pop ? m_q[0] : 1'b0;
    acc  = (esr || wr) && !s_waitrequest;

    check("s_address",    64'(s_address),        64'(ea));
    check("s_byteenable", 64'(s_byteenable),     64'(ebe));
    check("s_writedata",  64'(s_writedata),      64'(ewd));
    check("s_read",       64'(s_read),           64'(esr));
    check("s_write",      64'(s_write),          64'(wr));
    check("m0_wait",      64'(m0_waitrequest),   64'(ew0));
    check("m1_wait",      64'(m1_waitrequest),   64'(ew1));
    check("m0_rdy",       64'(m0_readdataready), 64'(pop && !head));
    check("m1_rdy",       64'(m1_readdataready), 64'(pop && head));
    check("m0_rdata",     64'(m0_readdata),      64'(s_readdata));
    check("m1_rdata",     64'(m1_readdata),      64'(s_readdata));
    check("busy",         64'(busy),             64'(m_own >= 0));
    check("grant",        64'(grant),            64'(m_own == 1));
    check("tag_err",      64'(tag_err),          64'(m_err));

    // Advance the model.
    if (s_readdataready && m_q.size() == 0) m_err = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (acc && esr) m_q.push_back(m_own[0]);
    req0 = m0_read;
    req1 = m1_read || m1_write;
    if (m_own < 0) begin
      if (req0 && req1) m_own = (m_last == 1) ? 0 : 1;
      else if (req0)    m_own = 0;
      else if (req1)    m_own = 1;
    end else begin
      reqx = (m_own == 0) ? req0 : req1;
      reqy = (m_own == 0) ? req1 : req0;
      if (!reqx || (acc && m_hold == MAX_HOLD - 1 && reqy)) begin
        if (reqx) n_handover++;
        m_last = m_own;
        m_hold = 0;
        m_own  = reqy ? 1 - m_own : -1;
      end else if (acc) begin
        m_hold = (m_hold + 1) % 16;
      end
    end
  endtask

  // Assert reset while masters and slave are active; everything must drop
  // to its idle values at once, without waiting for a clock edge.
  task automatic apply_reset();
    @(negedge clock);
    reset           = 1'b1;
    m0_read         = 1'b1;
    m1_read         = 1'b1;
    m1_write        = 1'b1;
    m0_address      = AW'($urandom);
    m1_address      = AW'($urandom);
    m1_writedata    = DW'($urandom);
    s_readdataready = 1'b1;
    s_waitrequest   = 1'b0;
    #1;
    model_reset();
    check("rst_busy",    64'(busy),             64'(0));
    check("rst_grant",   64'(grant),            64'(0));
    check("rst_s_read",  64'(s_read),           64'(0));
    check("rst_s_write", 64'(s_write),          64'(0));
    check("rst_s_addr",  64'(s_address),        64'(0));
    check("rst_m0_wait", 64'(m0_waitrequest),   64'(1));
    check("rst_m1_wait", 64'(m1_waitrequest),   64'(1));
    check("rst_m0_rdy",  64'(m0_readdataready), 64'(0));
    check("rst_m1_rdy",  64'(m1_readdataready), 64'(0));
    check("rst_tag_err", 64'(tag_err),          64'(0));
    @(negedge clock);
    reset           = 1'b0;
    m0_read         = 1'b0;
    m1_read         = 1'b0;
    m1_write        = 1'b0;
    s_readdataready = 1'b0;
  endtask

  initial begin
    apply_reset();
    // Mixed traffic with frequent returns.
    for (int i = 0; i < 600; i++) run_cycle(70, 30, 30, 20, 40, 0);
    // Both masters busy, slave rarely stalls: exercises the hold limit.
    for (int i = 0; i < 400; i++) run_cycle(95, 60, 40, 5, 35, 0);
    // Returns are rare, so the tag FIFO fills and reads back-pressure.
    for (int i = 0; i < 400; i++) run_cycle(90, 40, 20, 10, 3, 0);
    // Master 1 often raises read and write together.
    for (int i = 0; i < 400; i++) run_cycle(50, 80, 60, 20, 30, 0);
    // Drain all outstanding reads, then send a return with nothing pending.
    for (int i = 0; i < 30; i++)  run_cycle(0, 0, 0, 0, 100, 0);
    for (int i = 0; i < 3; i++)   run_cycle(0, 0, 0, 0, 0, 100);
    for (int i = 0; i < 50; i++)  run_cycle(60, 30, 30, 20, 40, 0);
    // Build up outstanding reads, reset mid-flight, then deliver late returns.
    for (int i = 0; i < 20; i++)  run_cycle(90, 40, 10, 10, 0, 0);
    apply_reset();
    for (int i = 0; i < 6; i++)   run_cycle(0, 0, 0, 0, 0, 60);
    for (int i = 0; i < 300; i++) run_cycle(70, 40, 30, 20, 40, 0);
    apply_reset();
    for (int i = 0; i < 300; i++) run_cycle(70, 40, 30, 20, 40, 0);
    // The stimulus must actually have reached the hold limit and a full FIFO.
    check("handover_seen", 64'(n_handover > 0), 64'(1));
    check("full_seen",     64'(n_full > 0),     64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
